// File: rtl/ioctl_load_sequencer_pkg.sv
// Shared types for the ioctl load sequencer: target indices,
// entry classes, FSM states and the buffered entry format.
package ioctl_load_pkg;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {
    CLS_ROM,
    CLS_MOD,
    CLS_DIP
  } cls_e;

  typedef enum logic [1:0] {
    HOLD,
    LOAD,
    DRAIN,
    RUN
  } st_e;

  typedef struct packed {
    cls_e        cls;
    logic [24:0] addr;
    logic [7:0]  data;
  } entry_t;

  function automatic logic idx_ok(
    input logic [7:0] idx
  );
    return (idx == IDX_ROM) ||
           (idx == IDX_MOD) ||
           (idx == IDX_DIP);
  endfunction

  function automatic cls_e idx_cls(
    input logic [7:0] idx
  );
    cls_e c;
    c = CLS_ROM;
    unique case (1'b1)
      idx == IDX_MOD: c = CLS_MOD;
      idx == IDX_DIP: c = CLS_DIP;
      default:        c = CLS_ROM;
    endcase
    return c;
  endfunction

  function automatic logic in_rom(
    input logic [24:0] a,
    input int          aw
  );
    return (a >> aw) == 25'd0;
  endfunction

endpackage

// File: rtl/ioctl_load_sequencer_if.sv
// ioctl download bus and ROM write handshake.
// master: HPS/ROM side, slave: the sequencer.
interface ioctl_load_sequencer_if #(
  parameter int ROM_AW = 16
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic              ioctl_wait;
  logic              rom_wr_req;
  logic [ROM_AW-1:0] rom_wr_addr;
  logic [7:0]        rom_wr_data;
  logic              rom_wr_ack;

  modport master (
    output ioctl_download, ioctl_wr,
    output ioctl_addr, ioctl_dout,
    output ioctl_index, rom_wr_ack,
    input  ioctl_wait, rom_wr_req,
    input  rom_wr_addr, rom_wr_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr,
    input  ioctl_addr, ioctl_dout,
    input  ioctl_index, rom_wr_ack,
    output ioctl_wait, rom_wr_req,
    output rom_wr_addr, rom_wr_data
  );
endinterface

// File: rtl/ioctl_load_sequencer_fifo.sv
// ioctl_entry_fifo: synchronous entry buffer with a
// one-behind peek so the ROM drain can chain requests.
module ioctl_entry_fifo
  import ioctl_load_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 head,
  output entry_t                 next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_cnt;
  logic            w_wr_ok;
  logic            w_rd_ok;

  assign full    = r_cnt == CW'(DEPTH);
  assign empty   = r_cnt == '0;
  assign count   = r_cnt;
  assign head    = r_mem[r_rd];
  assign next    = r_mem[r_rd + AW'(1)];
  assign w_rd_ok = pop && !empty;
  assign w_wr_ok = push && (!full || w_rd_ok);

  always_ff @(posedge clk_i) begin
    if (w_wr_ok) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr_ok) r_wr <= r_wr + AW'(1);
      if (w_rd_ok) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_wr_ok)
                     - CW'(w_rd_ok);
    end
  end

endmodule

// File: rtl/ioctl_load_sequencer.sv
// ioctl download sequencer: routes bytes to ROM/mod/DIP and
// owns CPU reset. LOAD_SEQ_CHECKSUM_EN adds the rom_sum output.
module ioctl_load_sequencer
  import ioctl_load_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         ROM_AW      = 16,
  parameter int         HOLD_CYCLES = 1024,
  parameter logic [7:0] MOD_DEFAULT = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_n,
  ioctl_load_sequencer_if.slave bus,
  input  logic        ext_reset,
  output logic [7:0]  mod,
  output logic [63:0] dsw,
  output logic        cpu_reset_n,
`ifdef LOAD_SEQ_CHECKSUM_EN
  output logic [15:0] rom_sum,
`endif
  output logic        overflow
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int HCW = $clog2(HOLD_CYCLES) + 1;

  entry_t            w_wentry;
  entry_t            w_head;
  entry_t            w_next;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_push;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_head_rom;
  logic              w_head_ok;
  logic              w_next_ok;

  st_e               r_state;
  logic [HCW-1:0]    r_hcnt;
  logic              r_cpu_n;
  logic              r_req;
  logic [ROM_AW-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_wait;
  logic              r_ovf;
  logic [7:0]        r_mod;
  logic [63:0]       r_dsw;

  assign w_push = bus.ioctl_wr &&
                  bus.ioctl_download &&
                  idx_ok(bus.ioctl_index);

  assign w_wentry = '{
    cls:  idx_cls(bus.ioctl_index),
    addr: bus.ioctl_addr,
    data: bus.ioctl_dout
  };

  ioctl_entry_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wentry),
    .head  (w_head),
    .next  (w_next),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  assign w_head_rom = !w_empty &&
                      w_head.cls == CLS_ROM;
  assign w_head_ok  = w_head_rom &&
                      in_rom(w_head.addr, ROM_AW);
  // peek lets req stay high across back-to-back ROM bytes
  assign w_next_ok  = (w_cnt >= CW'(2)) &&
                      w_next.cls == CLS_ROM &&
                      in_rom(w_next.addr, ROM_AW);

  always_comb begin
    w_pop = 1'b0;
    unique case (1'b1)
      w_empty:    w_pop = 1'b0;
      w_head_rom: w_pop = r_req ? bus.rom_wr_ack
                                : !w_head_ok;
      default:    w_pop = 1'b1;
    endcase
  end

  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_cnt_nxt = w_cnt + CW'(w_push_ok)
                           - CW'(w_pop);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      unique case (1'b1)
        !r_req && w_head_ok: begin
          r_req  <= 1'b1;
          r_addr <= w_head.addr[ROM_AW-1:0];
          r_data <= w_head.data;
        end
        r_req && bus.rom_wr_ack: begin
          r_req <= w_next_ok;
          if (w_next_ok) begin
            r_addr <= w_next.addr[ROM_AW-1:0];
            r_data <= w_next.data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_mod <= MOD_DEFAULT;
      r_dsw <= '0;
    end else if (w_pop && !w_head_rom) begin
      unique case (1'b1)
        w_head.cls == CLS_MOD:
          r_mod <= w_head.data;
        w_head.cls == CLS_DIP &&
        w_head.addr[24:3] == '0:
          r_dsw[{w_head.addr[2:0], 3'b000} +: 8]
            <= w_head.data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_wait <= w_cnt_nxt >= CW'(FIFO_DEPTH - 1);
      r_ovf  <= r_ovf |
                (w_push && w_full && !w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HOLD;
      r_hcnt  <= '0;
      r_cpu_n <= 1'b0;
    end else begin
      r_cpu_n <= r_state == RUN;
      if (bus.ioctl_download) begin
        r_state <= LOAD;
      end else begin
        unique case (r_state)
          HOLD: begin
            if (ext_reset) begin
              r_hcnt <= '0;
            end else if (r_hcnt ==
                HCW'(HOLD_CYCLES - 1)) begin
              r_state <= RUN;
            end else begin
              r_hcnt <= r_hcnt + HCW'(1);
            end
          end
          LOAD: r_state <= DRAIN;
          DRAIN: begin
            if (w_empty && !r_req) begin
              r_state <= HOLD;
              r_hcnt  <= '0;
            end
          end
          RUN: begin
            if (ext_reset) begin
              r_state <= HOLD;
              r_hcnt  <= '0;
            end
          end
          default: r_state <= HOLD;
        endcase
      end
    end
  end

`ifdef LOAD_SEQ_CHECKSUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (bus.ioctl_download &&
                 r_state != LOAD) begin
      r_sum <= '0;
    end else if ((r_state == LOAD ||
                  r_state == DRAIN) &&
                 r_req && bus.rom_wr_ack) begin
      r_sum <= r_sum + {8'h00, r_data};
    end
  end

  assign rom_sum = r_sum;
`endif

  assign bus.ioctl_wait  = r_wait;
  assign bus.rom_wr_req  = r_req;
  assign bus.rom_wr_addr = r_addr;
  assign bus.rom_wr_data = r_data;
  assign mod             = r_mod;
  assign dsw             = r_dsw;
  assign cpu_reset_n     = r_cpu_n;
  assign overflow        = r_ovf;

endmodule

// File: tb/tb_ioctl_load_sequencer.sv
// Directed bench for ioctl_load_sequencer: vector table for
// routing plus sequences for reset timing and backpressure.
module tb_ioctl_load_sequencer;

  localparam int HC = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_reset = 1'b0;
  logic [7:0]  mod;
  logic [63:0] dsw;
  logic        cpu_reset_n;
  logic        overflow;
`ifdef LOAD_SEQ_CHECKSUM_EN
  logic [15:0] rom_sum;
  logic [15:0] exp_sum;
`endif

  int checks = 0;
  int errors = 0;
  int n;
  int base;
  int nexp;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          bad;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] a;
    logic [7:0]  d;
    logic [7:0]  mod;
    logic [63:0] dsw;
    bit          rom;
    logic [15:0] ra;
    logic [7:0]  rd;
  } vec_t;
  vec_t tbl [11];

  ioctl_load_sequencer_if #(.ROM_AW(16)) bus ();

  ioctl_load_sequencer #(
    .FIFO_DEPTH  (4),
    .ROM_AW      (16),
    .HOLD_CYCLES (HC),
    .MOD_DEFAULT (8'hFF)
  ) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ext_reset   (ext_reset),
    .mod         (mod),
    .dsw         (dsw),
    .cpu_reset_n (cpu_reset_n),
`ifdef LOAD_SEQ_CHECKSUM_EN
    .rom_sum     (rom_sum),
`endif
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // ROM side: ack after rom_lat idle cycles, log each write
  int          rom_lat = 0;
  int          wcnt = 0;
  logic [15:0] ha;
  logic [7:0]  hd;
  bit          hbad;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.rom_wr_ack = 1'b0;
      wcnt = 0;
    end else begin
      if (bus.rom_wr_ack) begin
        bus.rom_wr_ack = 1'b0;
        wcnt = 0;
      end
      if (bus.rom_wr_req) begin
        if (wcnt == 0) begin
          ha = bus.rom_wr_addr;
          hd = bus.rom_wr_data;
          hbad = 1'b0;
        end else if (bus.rom_wr_addr !== ha ||
                     bus.rom_wr_data !== hd) begin
          hbad = 1'b1;
        end
        wcnt++;
        if (wcnt > rom_lat) begin
          bus.rom_wr_ack = 1'b1;
          wq.push_back('{ha, hd, hbad});
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0]  idx,
                           input logic [24:0] a,
                           input logic [7:0]  d);
    bus.ioctl_wr    = 1'b1;
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic cnt_run(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!cpu_reset_n && cyc < HC + 400);
  endtask

  task automatic wait_writes(input int target);
    int g;
    g = 0;
    while (wq.size() < target && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("write count", 64'(wq.size()), 64'(target));
  endtask

  initial begin
    tbl[0]  = '{8'd1,   25'h0,     8'h02, 8'h02,
                64'h0, 1'b0, 16'h0, 8'h0};
    tbl[1]  = '{8'd254, 25'h1,     8'h3C, 8'h02,
                64'h3C00, 1'b0, 16'h0, 8'h0};
    tbl[2]  = '{8'd254, 25'h9,     8'h77, 8'h02,
                64'h3C00, 1'b0, 16'h0, 8'h0};
    tbl[3]  = '{8'd254, 25'h7,     8'h5A, 8'h02,
                64'h5A00_0000_0000_3C00, 1'b0,
                16'h0, 8'h0};
    tbl[4]  = '{8'd0,   25'hFFFF,  8'h11, 8'h02,
                64'h5A00_0000_0000_3C00, 1'b1,
                16'hFFFF, 8'h11};
    tbl[5]  = '{8'd0,   25'h10000, 8'h22, 8'h02,
                64'h5A00_0000_0000_3C00, 1'b0,
                16'h0, 8'h0};
    tbl[6]  = '{8'd7,   25'h0,     8'h99, 8'h02,
                64'h5A00_0000_0000_3C00, 1'b0,
                16'h0, 8'h0};
    tbl[7]  = '{8'd1,   25'h123,   8'h80, 8'h80,
                64'h5A00_0000_0000_3C00, 1'b0,
                16'h0, 8'h0};
    tbl[8]  = '{8'd254, 25'h0,     8'hC3, 8'h80,
                64'h5A00_0000_0000_3CC3, 1'b0,
                16'h0, 8'h0};
    tbl[9]  = '{8'd254, 25'h8,     8'hEE, 8'h80,
                64'h5A00_0000_0000_3CC3, 1'b0,
                16'h0, 8'h0};
    tbl[10] = '{8'd2,   25'h5,     8'h44, 8'h80,
                64'h5A00_0000_0000_3CC3, 1'b0,
                16'h0, 8'h0};

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = '0;

    // reset values and release timing
    repeat (3) @(negedge clk);
    chk("rst wait", 64'(bus.ioctl_wait), 64'd0);
    chk("rst req", 64'(bus.rom_wr_req), 64'd0);
    chk("rst addr", 64'(bus.rom_wr_addr), 64'd0);
    chk("rst data", 64'(bus.rom_wr_data), 64'd0);
    chk("rst mod", 64'(mod), 64'hFF);
    chk("rst dsw", dsw, 64'd0);
    chk("rst cpu", 64'(cpu_reset_n), 64'd0);
    chk("rst ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    cnt_run(n);
    chk("reset release", 64'(n), 64'(HC + 1));
    chk("idle mod", 64'(mod), 64'hFF);
    chk("idle dsw", dsw, 64'd0);

    // 16-byte ROM download with slow acks
    @(negedge clk);
    rom_lat = 5;
    base = wq.size();
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    push_byte(8'd0, 25'd0, 8'h00 ^ 8'hA5);
    push_byte(8'd0, 25'd1, 8'h01 ^ 8'hA5);
    chk("wait at 2", 64'(bus.ioctl_wait), 64'd0);
    push_byte(8'd0, 25'd2, 8'h02 ^ 8'hA5);
    chk("wait at 3", 64'(bus.ioctl_wait), 64'd1);
    for (int i = 3; i < 16; i++) begin
      int g;
      g = 0;
      while (bus.ioctl_wait && g < 200) begin
        @(negedge clk);
        g++;
      end
      push_byte(8'd0, 25'(i), 8'(i) ^ 8'hA5);
    end
    chk("cpu in load", 64'(cpu_reset_n), 64'd0);
    bus.ioctl_download = 1'b0;
    wait_writes(base + 16);
    cnt_run(n);
    chk("drain release", 64'(n), 64'(HC + 2));
    for (int i = 0; i < 16; i++) begin
      if (base + i < wq.size())
        chk($sformatf("rom wr %0d", i),
            {39'd0, wq[base+i].bad,
             wq[base+i].a, wq[base+i].d},
            {39'd0, 1'b0, 16'(i),
             8'(i) ^ 8'hA5});
    end
`ifdef LOAD_SEQ_CHECKSUM_EN
    exp_sum = '0;
    for (int i = 0; i < 16; i++)
      exp_sum = exp_sum + {8'h00, 8'(i) ^ 8'hA5};
    chk("rom_sum", 64'(rom_sum), 64'(exp_sum));
`endif

    // single-entry routing table
    @(negedge clk);
    rom_lat = 0;
    base = wq.size();
    nexp = 0;
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      push_byte(tbl[i].idx, tbl[i].a, tbl[i].d);
      repeat (6) @(negedge clk);
      nexp += int'(tbl[i].rom);
      chk($sformatf("vec%0d mod", i),
          64'(mod), 64'(tbl[i].mod));
      chk($sformatf("vec%0d dsw", i),
          dsw, tbl[i].dsw);
      chk($sformatf("vec%0d rom cnt", i),
          64'(wq.size()), 64'(base + nexp));
      if (tbl[i].rom && wq.size() > 0)
        chk($sformatf("vec%0d rom wr", i),
            {40'd0, wq[$].a, wq[$].d},
            {40'd0, tbl[i].ra, tbl[i].rd});
    end
    bus.ioctl_download = 1'b0;

    // overflow: push past a full FIFO
    @(negedge clk);
    rom_lat = 30;
    base = wq.size();
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      push_byte(8'd0, 25'(32'h100 + i),
                8'(8'h40 + i));
    chk("ovf set", 64'(overflow), 64'd1);
    chk("ovf wait", 64'(bus.ioctl_wait), 64'd1);
    bus.ioctl_download = 1'b0;
    wait_writes(base + 4);
    repeat (40) @(negedge clk);
    chk("ovf count", 64'(wq.size()), 64'(base + 4));
    for (int k = 0; k < 4; k++) begin
      if (base + k < wq.size())
        chk($sformatf("ovf wr %0d", k),
            {40'd0, wq[base+k].a, wq[base+k].d},
            {40'd0, 16'(32'h100 + k),
             8'(8'h40 + k)});
    end
    chk("ovf sticky", 64'(overflow), 64'd1);

    // ext_reset in RUN, then download during HOLD
    cnt_run(n);
    chk("run again", 64'(cpu_reset_n), 64'd1);
    @(negedge clk);
    ext_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ext drop", 64'(cpu_reset_n), 64'd0);
    repeat (100) @(negedge clk);
    chk("ext held", 64'(cpu_reset_n), 64'd0);
    ext_reset = 1'b0;
    cnt_run(n);
    chk("ext release", 64'(n), 64'(HC + 1));
    @(negedge clk);
    ext_reset = 1'b1;
    @(negedge clk);
    ext_reset = 1'b0;
    repeat (10) @(negedge clk);
    bus.ioctl_download = 1'b1;
    repeat (3) @(negedge clk);
    chk("dl in hold", 64'(cpu_reset_n), 64'd0);
    bus.ioctl_download = 1'b0;
    cnt_run(n);
    chk("hold restart", 64'(n), 64'(HC + 3));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
